// File: rtl/multiplier_pkg.sv
// Shared constants and helpers for the structural array multiplier.
package multiplier_pkg;

    localparam int DEFAULT_WIDTH = 2;

    function automatic int calc_pw(input int width);
        return 2 * width;
    endfunction

    // Behavioural reference product, wide enough for the largest legal WIDTH.
    function automatic logic [31:0] mult_ref(input logic [15:0] a, input logic [15:0] b);
        return {16'd0, a} * {16'd0, b};
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; half-adder positions tie cin to zero.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplier_2x2.sv
// Unsigned structural array multiplier (AND plane + ripple adder rows) with a registered output.
module multiplier_2x2
    import multiplier_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int PW    = calc_pw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [PW-1:0]    P,
    output logic             out_valid
);

    logic [WIDTH-1:0] pp_s [WIDTH];
    logic [WIDTH-1:0] low_s;
    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    p_d, p_q;
    logic             out_valid_d, out_valid_q;

    genvar i, j;

    for (i = 0; i < WIDTH; i++) begin : g_pp
        assign pp_s[i] = A & {WIDTH{B[i]}};
    end

    // Each row retires one product bit into low_s and passes its upper WIDTH bits on.
    for (i = 0; i < WIDTH; i++) begin : g_row
        logic [WIDTH-1:0] upper_s;
        if (i == 0) begin : g_first
            assign upper_s  = {1'b0, pp_s[0][WIDTH-1:1]};
            assign low_s[0] = pp_s[0][0];
        end else begin : g_add
            for (j = 0; j < WIDTH; j++) begin : g_bit
                logic cin_s, s_s, cout_s;
                if (j == 0) begin : g_cin0
                    assign cin_s    = 1'b0;
                    assign low_s[i] = s_s;
                end else begin : g_cinj
                    assign cin_s        = g_bit[j-1].cout_s;
                    assign upper_s[j-1] = s_s;
                end
                if (j == WIDTH - 1) begin : g_top
                    assign upper_s[WIDTH-1] = cout_s;
                end
                full_adder u_fa (
                    .a    (pp_s[i][j]),
                    .b    (g_row[i-1].upper_s[j]),
                    .cin  (cin_s),
                    .s    (s_s),
                    .cout (cout_s)
                );
            end
        end
    end

    assign prod_s = {g_row[WIDTH-1].upper_s, low_s};

    // Capture only on valid cycles so idle (possibly X) operands never reach P.
    always_comb begin
        p_d         = p_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_d = prod_s;
        end else begin
            p_d = p_q;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= {PW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_2x2.sv
// Self-checking bench for multiplier_2x2 at WIDTH=2 and WIDTH=8 using a scoreboard queue.
module tb_multiplier_2x2;
    import multiplier_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid2, in_valid8;
    logic [1:0]  a2, b2;
    logic [7:0]  a8, b8;
    logic [3:0]  p2;
    logic [15:0] p8;
    logic        out_valid2, out_valid8;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] q2[$];
    logic [31:0] q8[$];
    logic [31:0] last2 = 32'd0;
    logic [31:0] last8 = 32'd0;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    multiplier_2x2 #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2),
        .A(a2), .B(b2), .P(p2), .out_valid(out_valid2)
    );

    multiplier_2x2 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8),
        .A(a8), .B(b8), .P(p8), .out_valid(out_valid8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycle2(input logic v, input logic [1:0] a, input logic [1:0] b,
                          input logic [31:0] exp, input string name);
        in_valid2 = v;
        a2 = a;
        b2 = b;
        if (v) q2.push_back(exp);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, {31'd0, out_valid2}, {31'd0, v});
        if (v) begin
            if (q2.size() > 0) last2 = q2.pop_front();
            else chk({name, "_underflow"}, 32'd1, 32'd0);
        end
        chk(name, {28'd0, p2}, last2);
    endtask

    task automatic cycle8(input logic v, input logic [7:0] a, input logic [7:0] b, input string name);
        logic [31:0] e;
        e = mult_ref({8'd0, a}, {8'd0, b});
        in_valid8 = v;
        a8 = a;
        b8 = b;
        if (v) q8.push_back(e);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, {31'd0, out_valid8}, {31'd0, v});
        if (v) begin
            if (q8.size() > 0) last8 = q8.pop_front();
            else chk({name, "_underflow"}, 32'd1, 32'd0);
        end
        chk(name, {16'd0, p8}, last8);
    endtask

    initial begin
        logic [31:0] e;
        vecs[0]  = '{2'd3, 2'd2, 32'd6, "dir_3x2"};
        vecs[1]  = '{2'd2, 2'd3, 32'd6, "dir_2x3"};
        vecs[2]  = '{2'd3, 2'd3, 32'd9, "dir_3x3"};
        vecs[3]  = '{2'd2, 2'd1, 32'd2, "dir_2x1"};
        vecs[4]  = '{2'd2, 2'd2, 32'd4, "dir_2x2"};
        vecs[5]  = '{2'd3, 2'd1, 32'd3, "dir_3x1"};
        vecs[6]  = '{2'd1, 2'd1, 32'd1, "dir_1x1"};
        vecs[7]  = '{2'd0, 2'd3, 32'd0, "zero_0x3"};
        vecs[8]  = '{2'd3, 2'd0, 32'd0, "zero_3x0"};
        vecs[9]  = '{2'd1, 2'd2, 32'd2, "ident_1x2"};
        vecs[10] = '{2'd0, 2'd0, 32'd0, "zero_0x0"};

        rst_n     = 1'b0;
        in_valid2 = 1'b1;
        a2        = 2'd3;
        b2        = 2'd3;
        in_valid8 = 1'b0;
        a8        = 8'd0;
        b8        = 8'd0;

        // Reset held with valid operands: outputs stay clear across edges.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_p2", {28'd0, p2}, 32'd0);
            chk("rst_valid2", {31'd0, out_valid2}, 32'd0);
            chk("rst_p8", {16'd0, p8}, 32'd0);
            chk("rst_valid8", {31'd0, out_valid8}, 32'd0);
        end
        rst_n = 1'b1;
        cycle2(1'b1, 2'd3, 2'd3, 32'd9, "post_rst_3x3");

        for (int k = 0; k < 11; k++) begin
            cycle2(1'b1, vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].name);
        end

        // Valid gating: P holds, and X operands on idle cycles are ignored.
        cycle2(1'b1, 2'd3, 2'd3, 32'd9, "gate_load");
        cycle2(1'b0, 2'd2, 2'd1, 32'd0, "gate_hold");
        cycle2(1'b0, 2'bxx, 2'bxx, 32'd0, "gate_xhold");

        // Asynchronous reset between edges while P=6.
        cycle2(1'b1, 2'd3, 2'd2, 32'd6, "pre_arst");
        in_valid2 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_p2", {28'd0, p2}, 32'd0);
        chk("arst_valid2", {31'd0, out_valid2}, 32'd0);
        last2 = 32'd0;
        #1;
        rst_n = 1'b1;
        cycle2(1'b0, 2'd3, 2'd3, 32'd0, "post_arst_idle");

        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                e = mult_ref(16'(a), 16'(b));
                cycle2(1'b1, 2'(a), 2'(b), e, "exh_w2");
            end
        end
        in_valid2 = 1'b0;

        cycle8(1'b1, 8'd255, 8'd255, "w8_max");
        chk("w8_max_value", {16'd0, p8}, 32'd65025);
        cycle8(1'b1, 8'd0, 8'd200, "w8_zero");
        cycle8(1'b1, 8'd1, 8'd173, "w8_ident");
        cycle8(1'b0, 8'd7, 8'd9, "w8_hold");
        for (int k = 0; k < 1000; k++) begin
            cycle8(($urandom_range(0, 9) != 0), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), "w8_rand");
        end
        in_valid8 = 1'b0;
        chk("q2_empty", q2.size(), 32'd0);
        chk("q8_empty", q8.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
